// File: rtl/alu_op_sequencer.sv
// Front-end controller for the 8-bit ALU: dispatches one (op, a, b) request to the
// selected functional unit over its start/done handshake and returns the result.
module alu_op_sequencer #(
    parameter int NUM_UNITS = 8,
    parameter int OP_W      = 3,
    parameter int TIMEOUT   = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [OP_W-1:0]         op,
    input  logic [7:0]              a,
    input  logic [7:0]              b,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [15:0]             res,
    output logic [7:0]              unit_a,
    output logic [7:0]              unit_b,
    output logic [NUM_UNITS-1:0]    unit_start,
    input  logic [NUM_UNITS-1:0]    unit_done,
    input  logic [16*NUM_UNITS-1:0] unit_res
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [OP_W:0] NUM_UNITS_EXT = (OP_W+1)'(NUM_UNITS);
    localparam logic [7:0]    TIMEOUT_LAST  = 8'(TIMEOUT - 1);

    state_t                 state;
    logic [OP_W-1:0]        op_latched;
    logic [7:0]             counter;

    logic                   op_valid;
    logic [NUM_UNITS-1:0]   op_onehot;
    logic                   sel_done;
    logic [15:0]            sel_res;

    assign busy     = (state != IDLE);
    assign op_valid = ({1'b0, op} < NUM_UNITS_EXT);

    always_comb begin
        op_onehot = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (op == OP_W'(k)) begin
                op_onehot[k] = 1'b1;
            end
        end
    end

    // Only the unit that was dispatched to can complete the operation.
    always_comb begin
        sel_done = 1'b0;
        sel_res  = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (op_latched == OP_W'(k)) begin
                sel_done = unit_done[k];
                sel_res  = unit_res[16*k +: 16];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            done       <= 1'b0;
            err        <= 1'b0;
            res        <= '0;
            unit_a     <= '0;
            unit_b     <= '0;
            unit_start <= '0;
            counter    <= '0;
            op_latched <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        unit_a     <= a;
                        unit_b     <= b;
                        op_latched <= op;
                        err        <= 1'b0;
                        if (op_valid) begin
                            unit_start <= op_onehot;
                            state      <= ISSUE;
                        end else begin
                            done <= 1'b1;
                            err  <= 1'b1;
                            res  <= '0;
                        end
                    end
                end
                ISSUE: begin
                    unit_start <= '0;
                    counter    <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    // A completion on the expiry edge still counts as success.
                    if (sel_done) begin
                        res   <= sel_res;
                        done  <= 1'b1;
                        err   <= 1'b0;
                        state <= IDLE;
                    end else if (counter == TIMEOUT_LAST) begin
                        res   <= '0;
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        counter <= counter + 8'd1;
                    end
                end
                default: begin
                    unit_start <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: six stub units with fixed latencies and a
// forcing vector for spurious/early unit_done pulses.
module tb_alu_op_sequencer;

    localparam int NU = 6;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [2:0]      op;
    logic [7:0]      a, b;
    logic            busy, done, err;
    logic [15:0]     res;
    logic [7:0]      unit_a, unit_b;
    logic [NU-1:0]   unit_start;
    logic [NU-1:0]   unit_done;
    logic [16*NU-1:0] unit_res;

    logic [NU-1:0]   stub_done;
    logic [NU-1:0]   force_done;
    int              cnt [NU];
    int              lat [NU] = '{3, 1, 0, 2, 4, 1};

    int compared   = 0;
    int mismatched = 0;

    alu_op_sequencer #(.NUM_UNITS(NU), .OP_W(3), .TIMEOUT(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .res        (res),
        .unit_a     (unit_a),
        .unit_b     (unit_b),
        .unit_start (unit_start),
        .unit_done  (unit_done),
        .unit_res   (unit_res)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] unit_fn(input int k, input logic [7:0] x, input logic [7:0] y);
        case (k)
            0:       return {8'h00, x & y};
            1:       return {8'h00, x | y};
            2:       return {8'h00, x ^ y};
            3:       return 16'(x) + 16'(y);
            4:       return 16'(x) - 16'(y);
            5:       return 16'(x) * 16'(y);
            default: return 16'h0000;
        endcase
    endfunction

    always_comb begin
        unit_res = '0;
        for (int k = 0; k < NU; k++) begin
            unit_res[16*k +: 16] = unit_fn(k, unit_a, unit_b);
        end
    end

    // Stub unit k raises done lat[k] edges after the edge that captured its start.
    always @(posedge clk) begin
        for (int k = 0; k < NU; k++) begin
            if (reset) begin
                cnt[k]       <= 0;
                stub_done[k] <= 1'b0;
            end else if (unit_start[k]) begin
                cnt[k]       <= lat[k];
                stub_done[k] <= 1'b0;
            end else begin
                stub_done[k] <= (cnt[k] == 1);
                if (cnt[k] > 0) cnt[k] <= cnt[k] - 1;
            end
        end
    end

    assign unit_done = stub_done | force_done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; force_done = '0;
        tick(); tick();
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_done",   32'(done), 32'd0);
        chk("rst_err",    32'(err), 32'd0);
        chk("rst_res",    32'(res), 32'd0);
        chk("rst_unit_a", 32'(unit_a), 32'd0);
        chk("rst_unit_b", 32'(unit_b), 32'd0);
        chk("rst_ustart", 32'(unit_start), 32'd0);
        reset = 1'b0;
        tick();

        // AND, L=3: accept at edge T, done set at edge T+5 (visible in cycle T+6)
        start = 1'b1; op = 3'd0; a = 8'hF0; b = 8'h3C;
        tick();                                     // T
        start = 1'b0;
        chk("and_ustart",  32'(unit_start), 32'h01);
        chk("and_busy",    32'(busy), 32'd1);
        chk("and_unit_a",  32'(unit_a), 32'hF0);
        chk("and_unit_b",  32'(unit_b), 32'h3C);
        tick();                                     // T+1
        chk("and_ustart_off", 32'(unit_start), 32'h00);
        tick(); tick(); tick();                     // T+2..T+4
        chk("and_not_yet", 32'(done), 32'd0);
        tick();                                     // T+5
        chk("and_done", 32'(done), 32'd1);
        chk("and_err",  32'(err), 32'd0);
        chk("and_res",  32'(res), 32'h0030);
        chk("and_idle", 32'(busy), 32'd0);
        tick();
        chk("and_pulse_1cyc", 32'(done), 32'd0);
        chk("and_res_hold",   32'(res), 32'h0030);

        // Unit 2 never completes; its done in the ISSUE cycle must be ignored; timeout after 5 WAIT edges
        start = 1'b1; op = 3'd2; a = 8'h01; b = 8'h02;
        tick();                                     // T
        start = 1'b0;
        force_done = 6'b000100;
        tick();                                     // T+1 (ISSUE)
        force_done = '0;
        chk("to_issue_ignored", 32'(done), 32'd0);
        tick(); tick(); tick(); tick();             // T+2..T+5
        chk("to_not_yet", 32'(done), 32'd0);
        chk("to_busy",    32'(busy), 32'd1);
        tick();                                     // T+6
        chk("to_done", 32'(done), 32'd1);
        chk("to_err",  32'(err), 32'd1);
        chk("to_res",  32'(res), 32'h0000);
        tick();

        // Unsupported ops: 7 and the boundary value NUM_UNITS
        start = 1'b1; op = 3'd7; a = 8'h55; b = 8'hAA;
        tick();
        start = 1'b0;
        chk("bad7_done",   32'(done), 32'd1);
        chk("bad7_err",    32'(err), 32'd1);
        chk("bad7_res",    32'(res), 32'h0000);
        chk("bad7_busy",   32'(busy), 32'd0);
        chk("bad7_ustart", 32'(unit_start), 32'h00);
        tick();
        chk("bad7_pulse", 32'(done), 32'd0);
        start = 1'b1; op = 3'd6;
        tick();
        start = 1'b0;
        chk("bad6_err",  32'(err), 32'd1);
        chk("bad6_busy", 32'(busy), 32'd0);
        tick();

        // ADD with start held high and new operands while busy, then back-to-back OR
        start = 1'b1; op = 3'd3; a = 8'h80; b = 8'h90;
        tick();                                     // T
        op = 3'd1; a = 8'h11; b = 8'h22;
        tick();                                     // T+1
        chk("busy_no_reissue", 32'(unit_start), 32'h00);
        tick(); tick();                             // T+2, T+3
        chk("busy_unit_a_held", 32'(unit_a), 32'h80);
        chk("busy_still",       32'(busy), 32'd1);
        tick();                                     // T+4
        chk("add_done", 32'(done), 32'd1);
        chk("add_res",  32'(res), 32'h0110);
        chk("add_err",  32'(err), 32'd0);
        tick();                                     // T+5: accepted in the done cycle
        start = 1'b0;
        chk("b2b_ustart", 32'(unit_start), 32'h02);
        chk("b2b_unit_a", 32'(unit_a), 32'h11);
        chk("b2b_done_low", 32'(done), 32'd0);
        tick(); tick(); tick();                     // T+6..T+8
        chk("or_done", 32'(done), 32'd1);
        chk("or_res",  32'(res), 32'h0033);
        tick();

        // SUB (L=4) completes on the timeout edge; other units pulse done during WAIT
        start = 1'b1; op = 3'd4; a = 8'h10; b = 8'h20;
        tick();                                     // T
        start = 1'b0;
        tick();                                     // T+1
        force_done = 6'b101111;
        tick();                                     // T+2
        chk("other_ignored_a", 32'(done), 32'd0);
        tick();                                     // T+3
        chk("other_ignored_b", 32'(busy), 32'd1);
        force_done = '0;
        tick(); tick();                             // T+4, T+5
        chk("sub_not_yet", 32'(done), 32'd0);
        tick();                                     // T+6
        chk("edge_done", 32'(done), 32'd1);
        chk("edge_err",  32'(err), 32'd0);
        chk("edge_res",  32'(res), 32'hFFF0);
        tick();

        // Reset in WAIT, then a fresh MUL
        start = 1'b1; op = 3'd0; a = 8'hFF; b = 8'h0F;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_busy",   32'(busy), 32'd0);
        chk("mid_rst_done",   32'(done), 32'd0);
        chk("mid_rst_ustart", 32'(unit_start), 32'h00);
        chk("mid_rst_res",    32'(res), 32'h0000);
        reset = 1'b0;
        tick();
        chk("mid_rst_no_pulse", 32'(done), 32'd0);
        start = 1'b1; op = 3'd5; a = 8'h0C; b = 8'h0D;
        tick();                                     // T
        start = 1'b0;
        chk("mul_ustart", 32'(unit_start), 32'h20);
        tick(); tick(); tick();                     // T+1..T+3
        chk("mul_done", 32'(done), 32'd1);
        chk("mul_res",  32'(res), 32'h009C);
        chk("mul_err",  32'(err), 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
